// File: rtl/bitcell_array_ctrl_pkg.sv
// Shared types and constants for the bitcell array controller.
package bitcell_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    VERIFY = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/bitcell_array_ctrl_row_decoder.sv
// Combinational row decoder: address plus enable to one-hot row select.
module row_decoder #(
  parameter int ADDR_W = 2
) (
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic                   i_en,
  output logic [(2**ADDR_W)-1:0] o_sel
);

  always_comb begin
    o_sel = '0;
    if (i_en) o_sel[i_addr] = 1'b1;
  end

endmodule

// File: rtl/bitcell_array_ctrl.sv
// Access controller for a word-organised bitcell array.
// Optional write-verify read-back enabled by BITCELL_ARRAY_CTRL_WRITE_VERIFY_EN.
module bitcell_array_ctrl
  import bitcell_pkg::*;
#(
  parameter int ADDR_W        = 2,
  parameter int DATA_W        = 4,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [(2**ADDR_W)-1:0] arr_sel,
  output logic                   arr_rw,
  output logic [DATA_W-1:0]      arr_wdata,
  input  logic [DATA_W-1:0]      arr_rdata
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);

  state_t              r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_drive;
  logic                w_sel_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= RW_READ;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= (req_we == RW_WRITE) ? req_wdata : '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_cnt   <= CNT_W'(ACCESS_CYCLES - 1);
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            if (r_we == RW_READ) r_rdata <= arr_rdata;
`ifdef BITCELL_ARRAY_CTRL_WRITE_VERIFY_EN
            if (r_we == RW_WRITE) begin
              r_cnt   <= CNT_W'(ACCESS_CYCLES);
              r_state <= VERIFY;
            end else begin
              r_state <= RESP;
            end
`else
            r_state <= RESP;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`ifdef BITCELL_ARRAY_CTRL_WRITE_VERIFY_EN
        VERIFY: begin
          if (r_cnt == '0) begin
            r_err   <= (arr_rdata != r_wdata);
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`endif
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Drive rw/data through SETUP and ACCESS only, so select never overlaps a data edge.
  assign w_drive = (r_state == SETUP) || (r_state == ACCESS);

`ifdef BITCELL_ARRAY_CTRL_WRITE_VERIFY_EN
  // First VERIFY cycle (counter still full) is the de-select gap before read-back.
  assign w_sel_en = (r_state == ACCESS) ||
                    ((r_state == VERIFY) && (r_cnt != CNT_W'(ACCESS_CYCLES)));
`else
  assign w_sel_en = (r_state == ACCESS);
`endif

  row_decoder #(
    .ADDR_W (ADDR_W)
  ) u_row_decoder (
    .i_addr (r_addr),
    .i_en   (w_sel_en),
    .o_sel  (arr_sel)
  );

  assign arr_rw    = (w_drive && (r_we == RW_WRITE)) ? RW_WRITE : RW_READ;
  assign arr_wdata = w_drive ? r_wdata : '0;
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Self-checking bench for bitcell_array_ctrl with a 4x4 bitcell array model.
module tb_bitcell_array_ctrl;

  localparam int AW = 2;
  localparam int DW = 4;
  localparam int AC = 2;
`ifdef BITCELL_ARRAY_CTRL_WRITE_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [3:0]    arr_sel;
  logic          arr_rw;
  logic [DW-1:0] arr_wdata;
  logic [DW-1:0] arr_rdata;

  int total = 0;
  int bad   = 0;

  bitcell_array_ctrl #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .ACCESS_CYCLES (AC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .arr_sel   (arr_sel),
    .arr_rw    (arr_rw),
    .arr_wdata (arr_wdata),
    .arr_rdata (arr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bitcell array environment: per-row storage, optional stuck-at-0 bits, wired-OR read.
  logic [DW-1:0] mem_m   [4] = '{default: '0};
  logic [DW-1:0] stuck_m [4];

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++)
      if (arr_sel[r] && arr_rw) mem_m[r] <= arr_wdata;
  end

  always_comb begin
    arr_rdata = '0;
    for (int r = 0; r < 4; r++)
      if (arr_sel[r]) arr_rdata = arr_rdata | (mem_m[r] & ~stuck_m[r]);
  end

  // Reference: what a read of each row should return.
  logic [DW-1:0] ref_mem [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int hold, input bit busy);
    int k;
    int lat;
    logic [3:0]    oh;
    logic [DW-1:0] exp_wd;
    logic [DW-1:0] exp_rd;
    logic          exp_err;
    oh      = 4'b0001 << addr;
    exp_wd  = we ? wdata : '0;
    exp_rd  = we ? '0 : ref_mem[addr];
    lat     = (we && VERIFY_ON) ? 3 + 2 * AC : 2 + AC;
    exp_err = VERIFY_ON && we && ((wdata & ~stuck_m[addr]) != wdata);

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", 32'(req_ready), 32'd1);

    @(negedge clk);
    if (busy) begin
      req_addr  = ~addr;
      req_wdata = ~wdata;
      req_we    = ~we;
    end else begin
      req_valid = 1'b0;
    end
    k = 1;
    while (!rsp_valid && k <= 20) begin
      if (k == 1) begin
        chk("setup_sel", 32'(arr_sel), 32'd0);
        chk("setup_rw", 32'(arr_rw), 32'(we));
        chk("setup_wdata", 32'(arr_wdata), 32'(exp_wd));
      end else if (k <= 1 + AC) begin
        chk("access_sel", 32'(arr_sel), 32'(oh));
        chk("access_rw", 32'(arr_rw), 32'(we));
        chk("access_wdata", 32'(arr_wdata), 32'(exp_wd));
      end else if (k == 2 + AC) begin
        chk("verify_gap_sel", 32'(arr_sel), 32'd0);
        chk("verify_gap_rw", 32'(arr_rw), 32'd0);
      end else begin
        chk("verify_sel", 32'(arr_sel), 32'(oh));
        chk("verify_rw", 32'(arr_rw), 32'd0);
      end
      if (busy) chk("busy_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(lat));

    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_ready_low", 32'(req_ready), 32'd0);
    chk("resp_sel", 32'(arr_sel), 32'd0);
    chk("resp_rw", 32'(arr_rw), 32'd0);
    chk("resp_wdata", 32'(arr_wdata), 32'd0);
    chk("resp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    chk("resp_err", 32'(rsp_err), 32'(exp_err));
    req_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", 32'(rsp_rdata), 32'(exp_rd));
      chk("hold_err", 32'(rsp_err), 32'(exp_err));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
    chk("post_sel", 32'(arr_sel), 32'd0);

    if (we) ref_mem[addr] = wdata & ~stuck_m[addr];
  endtask

  initial begin
    for (int r = 0; r < 4; r++) begin
      stuck_m[r] = '0;
      ref_mem[r] = '0;
    end
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(arr_sel), 32'd0);
    chk("rst_rw", 32'(arr_rw), 32'd0);
    chk("rst_wdata", 32'(arr_wdata), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 32'd1);

    // Reset in the middle of a write access to row 2.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 2'd2;
    req_wdata = 4'h7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_sel_before", 32'(arr_sel), 32'b0100);
    rst_n = 1'b0;
    #1;
    chk("midrst_sel", 32'(arr_sel), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd1);

    // Known contents in every row.
    do_req(1'b1, 2'd0, 4'h1, 0, 1'b0);
    do_req(1'b1, 2'd1, 4'h6, 0, 1'b0);
    do_req(1'b1, 2'd2, 4'h9, 0, 1'b0);
    do_req(1'b1, 2'd3, 4'hC, 0, 1'b0);

    // Write then read back, with a busy requester and response backpressure.
    do_req(1'b1, 2'd1, 4'hA, 0, 1'b0);
    do_req(1'b0, 2'd1, 4'h0, 5, 1'b1);

    // Row isolation.
    do_req(1'b1, 2'd0, 4'h5, 0, 1'b0);
    do_req(1'b1, 2'd3, 4'h3, 0, 1'b0);
    do_req(1'b0, 2'd0, 4'h0, 0, 1'b0);
    do_req(1'b0, 2'd3, 4'h0, 0, 1'b0);
    do_req(1'b0, 2'd1, 4'h0, 1, 1'b0);
    do_req(1'b0, 2'd2, 4'h0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), $urandom_range(0, 2),
             1'($urandom_range(0, 1)));
    end

`ifdef BITCELL_ARRAY_CTRL_WRITE_VERIFY_EN
    stuck_m[2] = 4'b0001;
    do_req(1'b1, 2'd2, 4'hF, 0, 1'b0);
    do_req(1'b1, 2'd2, 4'hE, 0, 1'b0);
    do_req(1'b0, 2'd2, 4'h0, 0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitcell_array_ctrl.md
Name: bitcell_array_ctrl

Overview:
- Synchronous access controller and initiator for a word-organised array of bitcell storage cells.
- Accepts single read/write requests on a valid/ready interface, decodes the address to a one-hot row select, and drives the array's sel/rw/data wires with setup and hold margins.
- Captures read data from the array's out wires and returns one response per request.
- Sits between the system-side requester and the bitcell array.

Parameters:
- ADDR_W, 2, row address width; the array has 2**ADDR_W rows.
- DATA_W, 4, word width; one bitcell per bit per row.
- ACCESS_CYCLES, 2, cycles sel stays asserted per access; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  row address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  write-verify mismatch; 0 when the feature is absent.
- arr_sel  out  2**ADDR_W  one-hot row select to the bitcells.
- arr_rw  out  1  to the bitcells' rw input; 1 = write, 0 = read.
- arr_wdata  out  DATA_W  to the bitcells' data inputs.
- arr_rdata  in  DATA_W  from the selected row's out wires, wired-OR across rows.

Behaviour:
- Reset, asynchronous:
  - state = IDLE.
  - arr_sel = 0, arr_rw = 0, arr_wdata = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 1 once reset is released.
- FSM states: IDLE, SETUP, ACCESS, (VERIFY), RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, register we/addr/wdata and go to SETUP.
- SETUP, 1 cycle:
  - arr_rw = we, arr_wdata = wdata (0 for reads), arr_sel = 0.
  - Gives address and data setup before select.
- ACCESS, ACCESS_CYCLES cycles:
  - arr_sel = one-hot(addr); arr_rw and arr_wdata stay stable.
  - On the last cycle of a read, rsp_rdata <= arr_rdata.
  - Then go to RESP, or to VERIFY for a write when the feature is enabled.
- RESP:
  - arr_sel = 0, arr_rw = 0, arr_wdata = 0.
  - rsp_valid = 1; rsp_rdata and rsp_err stay stable until rsp_ready.
  - On rsp_ready, go to IDLE and clear rsp_valid.
  - rsp_ready held high gives a 1-cycle RESP.
- Timing:
  - arr_sel is never asserted in the same cycle arr_rw or arr_wdata changes value.
  - Accept-to-rsp_valid latency = 2 + ACCESS_CYCLES cycles; 4 at defaults.
  - Best-case throughput: one request per 3 + ACCESS_CYCLES cycles.
- req_ready is 0 in every state except IDLE. req_valid while busy is ignored; the requester must hold it.
- Out-of-range address is impossible because the address is full width.
- Reset mid-operation: arr_sel drops immediately, the pending request and response are lost, and the contents of the row being written are undefined.
- rsp_ready while rsp_valid = 0 has no effect.

Optional Feature:
- Macro: BITCELL_ARRAY_CTRL_WRITE_VERIFY_EN.
- Defined:
  - A write goes ACCESS -> VERIFY.
  - VERIFY lasts 1 + ACCESS_CYCLES cycles: first a de-select cycle with arr_sel = 0 and arr_rw = 0, then arr_sel = one-hot(addr) with arr_rw = 0 for ACCESS_CYCLES cycles.
  - On the last VERIFY cycle, rsp_err <= (arr_rdata != wdata).
  - Write latency = 3 + 2*ACCESS_CYCLES cycles.
  - rsp_rdata = 0 for writes.
- Undefined: no VERIFY state, rsp_err tied to 0.

Decomposition:
- Package bitcell_pkg holds:
  - state enum: IDLE, SETUP, ACCESS, VERIFY, RESP.
  - constants RW_WRITE = 1'b1 and RW_READ = 1'b0.
- Sub-module row_decoder (parameter ADDR_W): combinational addr + enable to a one-hot 2**ADDR_W vector.
- One down-counter of width clog2(ACCESS_CYCLES+1) sits in the top level.

Test Plan (defaults; bench models a 4x4 bitcell array):
- Reset: assert rst_n = 0 mid-ACCESS of a write to addr 2 -> arr_sel = 0 immediately, rsp_valid = 0; req_ready = 1 after release.
- Write then read: write 4'hA to addr 1, then read addr 1 -> the write response arrives 4 cycles after accept with rsp_rdata = 0; the read returns rsp_rdata = 4'hA after 4 cycles; arr_sel = 4'b0010 only during ACCESS.
- Setup check: for each access, check arr_rw and arr_wdata are stable in the SETUP cycle and every ACCESS cycle; arr_sel = 0 in SETUP and RESP.
- Busy and backpressure: second req_valid during ACCESS -> req_ready = 0 and the request is not taken; hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable; then accept.
- Row isolation: write 4'h5 to addr 0 and 4'h3 to addr 3 -> reads return 4'h5 and 4'h3; rows 1 and 2 are untouched.
- Feature on: force a stuck-at-0 bit 0 in row 2, write 4'hF to addr 2 -> rsp_err = 1, latency 7 cycles; write 4'hE -> rsp_err = 0.
